// File: rtl/ddr3_ui_traffic_gen_if.sv
// Local user interface of the DDR3 x16 controller: command, write-data and read-data channels.
// The traffic generator is the master; the controller (or its model) is the slave.
interface ddr3_ui_traffic_gen_if;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        cmd_rdy;
    logic [25:0] addr;
    logic [4:0]  cmd_burst_cnt;
    logic        ofly_burst_len;
    logic        datain_rdy;
    logic [63:0] write_data;
    logic [7:0]  data_mask;
    logic [63:0] read_data;
    logic        read_data_valid;

    modport master (
        output cmd, cmd_valid, addr, cmd_burst_cnt, ofly_burst_len, write_data, data_mask,
        input  cmd_rdy, datain_rdy, read_data, read_data_valid
    );

    modport slave (
        input  cmd, cmd_valid, addr, cmd_burst_cnt, ofly_burst_len, write_data, data_mask,
        output cmd_rdy, datain_rdy, read_data, read_data_valid
    );
endinterface

// File: rtl/ddr3_ui_traffic_gen.sv
// Write/read-verify traffic generator for the DDR3 controller user interface (sclk domain).
// Writes NUM_CMDS BL8 commands of a seeded pattern, reads them back and reports errors.
module ddr3_ui_traffic_gen #(
    parameter int unsigned NUM_CMDS  = 256,
    parameter logic [25:0] BASE_ADDR = 26'h0,
    parameter logic [25:0] ADDR_STEP = 26'd8,
    parameter logic [31:0] SEED      = 32'hA5A5_0000,
    parameter int unsigned TIMEOUT   = 4096,
    parameter logic [3:0]  CMD_RD    = 4'b0001,
    parameter logic [3:0]  CMD_WR    = 4'b0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_done,
    input  logic                  start,
    ddr3_ui_traffic_gen_if.master ui,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [25:0]           first_err_addr
);

    typedef enum logic [2:0] {StIdle, StWrCmd, StWrData, StRdCmd, StRdWait, StDone} state_e;

    localparam logic [31:0] LastIdx = 32'(NUM_CMDS - 1);
    localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
    logic [15:0] err_count_q, err_count_d;
    logic [25:0] first_err_addr_q, first_err_addr_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [25:0] addr_q, addr_d;
    logic [63:0] write_data_q, write_data_d;
    logic [31:0] cmd_idx_q, cmd_idx_d;
    logic        beat_q, beat_d;
    logic [31:0] chk_idx_q, chk_idx_d;
    logic        chk_beat_q, chk_beat_d;
    logic [25:0] chk_addr_q, chk_addr_d;
    logic        cmp_vld_q, cmp_vld_d, cmp_err_q, cmp_err_d, cmp_last_q, cmp_last_d;
    logic [25:0] cmp_addr_q, cmp_addr_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        accept, progress, reading, active;

    function automatic logic [63:0] pattern(input logic [31:0] idx, input logic beat);
        return {idx ^ SEED, ~idx[30:0], beat};
    endfunction

    always_comb begin
        state_d          = state_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        cmd_valid_d      = cmd_valid_q;
        cmd_d            = cmd_q;
        addr_d           = addr_q;
        write_data_d     = write_data_q;
        cmd_idx_d        = cmd_idx_q;
        beat_d           = beat_q;
        chk_idx_d        = chk_idx_q;
        chk_beat_d       = chk_beat_q;
        chk_addr_d       = chk_addr_q;
        cmp_vld_d        = 1'b0;
        cmp_err_d        = cmp_err_q;
        cmp_last_d       = cmp_last_q;
        cmp_addr_d       = cmp_addr_q;

        accept   = cmd_valid_q && ui.cmd_rdy;
        progress = accept || ui.datain_rdy || ui.read_data_valid;
        reading  = (state_q == StRdCmd) || (state_q == StRdWait);
        active   = (state_q != StIdle) && (state_q != StDone);
        tmo_cnt_d = progress ? 32'd0 : tmo_cnt_q + 32'd1;

        // Compare stage 1: register the beat comparison, independent of read issue.
        if (reading && ui.read_data_valid) begin
            cmp_vld_d  = 1'b1;
            cmp_err_d  = ui.read_data != pattern(chk_idx_q, chk_beat_q);
            cmp_addr_d = chk_addr_q;
            cmp_last_d = chk_beat_q && (chk_idx_q == LastIdx);
            chk_beat_d = ~chk_beat_q;
            if (chk_beat_q) begin
                chk_idx_d  = chk_idx_q + 32'd1;
                chk_addr_d = chk_addr_q + ADDR_STEP;
            end
        end

        // Compare stage 2: accumulate errors.
        if (reading && cmp_vld_q && cmp_err_q) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0) first_err_addr_d = cmp_addr_q;
        end

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start && init_done) begin
                    state_d          = StWrCmd;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    timeout_d        = 1'b0;
                    err_count_d      = 16'd0;
                    first_err_addr_d = 26'd0;
                    cmd_valid_d      = 1'b1;
                    cmd_d            = CMD_WR;
                    addr_d           = BASE_ADDR;
                    cmd_idx_d        = 32'd0;
                    beat_d           = 1'b0;
                    chk_idx_d        = 32'd0;
                    chk_beat_d       = 1'b0;
                    chk_addr_d       = BASE_ADDR;
                    tmo_cnt_d        = 32'd0;
                end
            end
            StWrCmd: begin
                if (accept) begin
                    cmd_valid_d  = 1'b0;
                    write_data_d = pattern(cmd_idx_q, 1'b0);
                    state_d      = StWrData;
                end
            end
            StWrData: begin
                if (ui.datain_rdy) begin
                    if (!beat_q) begin
                        beat_d       = 1'b1;
                        write_data_d = pattern(cmd_idx_q, 1'b1);
                    end else begin
                        beat_d      = 1'b0;
                        cmd_valid_d = 1'b1;
                        if (cmd_idx_q == LastIdx) begin
                            cmd_idx_d = 32'd0;
                            cmd_d     = CMD_RD;
                            addr_d    = BASE_ADDR;
                            state_d   = StRdCmd;
                        end else begin
                            cmd_idx_d = cmd_idx_q + 32'd1;
                            cmd_d     = CMD_WR;
                            addr_d    = addr_q + ADDR_STEP;
                            state_d   = StWrCmd;
                        end
                    end
                end
            end
            StRdCmd: begin
                if (accept) begin
                    if (cmd_idx_q == LastIdx) begin
                        cmd_valid_d = 1'b0;
                        state_d     = StRdWait;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 32'd1;
                        addr_d    = addr_q + ADDR_STEP;
                    end
                end
            end
            StRdWait: ;
            default: state_d = StIdle;
        endcase

        if (reading && cmp_vld_q && cmp_last_q) begin
            state_d     = StDone;
            cmd_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = (err_count_d == 16'd0) && !timeout_q;
        end

        if (active && !progress && (tmo_cnt_q == TmoLast)) begin
            state_d     = StDone;
            cmd_valid_d = 1'b0;
            timeout_d   = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_count_q      <= 16'd0;
            first_err_addr_q <= 26'd0;
            cmd_valid_q      <= 1'b0;
            cmd_q            <= 4'd0;
            addr_q           <= 26'd0;
            write_data_q     <= 64'd0;
            cmd_idx_q        <= 32'd0;
            beat_q           <= 1'b0;
            chk_idx_q        <= 32'd0;
            chk_beat_q       <= 1'b0;
            chk_addr_q       <= 26'd0;
            cmp_vld_q        <= 1'b0;
            cmp_err_q        <= 1'b0;
            cmp_last_q       <= 1'b0;
            cmp_addr_q       <= 26'd0;
            tmo_cnt_q        <= 32'd0;
        end else begin
            state_q          <= state_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            cmd_valid_q      <= cmd_valid_d;
            cmd_q            <= cmd_d;
            addr_q           <= addr_d;
            write_data_q     <= write_data_d;
            cmd_idx_q        <= cmd_idx_d;
            beat_q           <= beat_d;
            chk_idx_q        <= chk_idx_d;
            chk_beat_q       <= chk_beat_d;
            chk_addr_q       <= chk_addr_d;
            cmp_vld_q        <= cmp_vld_d;
            cmp_err_q        <= cmp_err_d;
            cmp_last_q       <= cmp_last_d;
            cmp_addr_q       <= cmp_addr_d;
            tmo_cnt_q        <= tmo_cnt_d;
        end
    end

    assign ui.cmd            = cmd_q;
    assign ui.cmd_valid      = cmd_valid_q;
    assign ui.addr           = addr_q;
    assign ui.cmd_burst_cnt  = 5'd1;
    assign ui.ofly_burst_len = 1'b0;
    assign ui.write_data     = write_data_q;
    assign ui.data_mask      = 8'd0;

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_ddr3_ui_traffic_gen.sv
// Directed bench for ddr3_ui_traffic_gen with a small controller model (write capture, 10-cycle
// read latency, optional corruption / silent reads).
module tb_ddr3_ui_traffic_gen;

    localparam logic [3:0] CMD_RD = 4'b0001;
    localparam logic [3:0] CMD_WR = 4'b0010;

    logic        clk = 1'b0;
    logic        rst, init_done, start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [25:0] first_err_addr;

    ddr3_ui_traffic_gen_if ui ();

    ddr3_ui_traffic_gen #(
        .NUM_CMDS (4),
        .TIMEOUT  (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .init_done      (init_done),
        .start          (start),
        .ui             (ui),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Controller model state
    logic        corrupt = 1'b0;
    logic        no_read = 1'b0;
    logic [63:0] mem [8][2];
    logic [25:0] wr_log [64];
    int unsigned wr_n = 0, rd_n = 0, n_hs = 0, cyc = 0, last_prog = 0, wr_left = 0;
    logic [25:0] wr_cur = '0, rd_cur = '0;
    logic        wr_b = 1'b0, rd_beat1 = 1'b0;
    logic [26:0] rd_pipe [10];
    logic [25:0] rq [$];

    function automatic logic [63:0] rd_beat(input logic [25:0] a, input logic b);
        logic [63:0] d;
        d = mem[a[5:3]][b];
        if (corrupt && a == 26'd16 && b) d[0] = ~d[0];
        return d;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((ui.cmd_valid && ui.cmd_rdy) || ui.datain_rdy || ui.read_data_valid) last_prog <= cyc;
        if (ui.cmd_valid && ui.cmd_rdy) n_hs <= n_hs + 1;
        if (rst) begin
            ui.datain_rdy      <= 1'b0;
            ui.read_data_valid <= 1'b0;
            ui.read_data       <= '0;
            wr_left            <= 0;
            rd_beat1           <= 1'b0;
            rq.delete();
            for (int k = 0; k < 10; k++) rd_pipe[k] <= '0;
        end else begin
            if (ui.cmd_valid && ui.cmd_rdy && ui.cmd == CMD_WR) begin
                wr_log[wr_n[5:0]] <= ui.addr;
                wr_n          <= wr_n + 1;
                wr_cur        <= ui.addr;
                wr_b          <= 1'b0;
                ui.datain_rdy <= 1'b1;
                wr_left       <= 1;
            end else if (wr_left != 0) begin
                ui.datain_rdy <= 1'b1;
                wr_left       <= wr_left - 1;
            end else begin
                ui.datain_rdy <= 1'b0;
            end
            if (ui.datain_rdy) begin
                mem[wr_cur[5:3]][wr_b] <= ui.write_data;
                wr_b <= ~wr_b;
            end
            if (ui.cmd_valid && ui.cmd_rdy && ui.cmd == CMD_RD) rd_n <= rd_n + 1;
            for (int k = 9; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
            rd_pipe[0] <= {ui.cmd_valid && ui.cmd_rdy && ui.cmd == CMD_RD && !no_read, ui.addr};
            if (rd_pipe[9][26]) rq.push_back(rd_pipe[9][25:0]);
            ui.read_data_valid <= 1'b0;
            if (rd_beat1) begin
                ui.read_data_valid <= 1'b1;
                ui.read_data       <= rd_beat(rd_cur, 1'b1);
                rd_beat1           <= 1'b0;
            end else if (rq.size() != 0) begin
                ui.read_data_valid <= 1'b1;
                ui.read_data       <= rd_beat(rq[0], 1'b0);
                rd_cur             <= rq[0];
                rd_beat1           <= 1'b1;
                rq.pop_front();
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_valid"}, 64'(ui.cmd_valid), 64'd0);
        chk({tag, "_cmd"}, 64'(ui.cmd), 64'd0);
        chk({tag, "_addr"}, 64'(ui.addr), 64'd0);
        chk({tag, "_wdata"}, ui.write_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_err"}, 64'(err_count), 64'd0);
        chk({tag, "_first"}, 64'(first_err_addr), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned wb, rb, hs0;
        rst = 1'b1; init_done = 1'b0; start = 1'b0; ui.cmd_rdy = 1'b1;
        tick(3);
        chk_reset_vals("reset");
        chk("burst_cnt", 64'(ui.cmd_burst_cnt), 64'd1);
        chk("ofly", 64'(ui.ofly_burst_len), 64'd0);
        chk("mask", 64'(ui.data_mask), 64'd0);
        rst = 1'b0;
        tick(2);

        // start without init_done
        pulse_start();
        tick(3);
        chk("noinit_busy", 64'(busy), 64'd0);
        chk("noinit_cmd_valid", 64'(ui.cmd_valid), 64'd0);
        chk("noinit_done", 64'(done), 64'd0);

        // Run 1: clean pass
        init_done = 1'b1;
        wb = wr_n; rb = rd_n;
        pulse_start();
        chk("r1_busy", 64'(busy), 64'd1);
        chk("r1_cmd_valid", 64'(ui.cmd_valid), 64'd1);
        chk("r1_cmd", 64'(ui.cmd), 64'(CMD_WR));
        chk("r1_addr0", 64'(ui.addr), 64'd0);
        tick(5);
        pulse_start();  // ignored while busy
        wait_done("r1_done");
        chk("r1_pass", 64'(pass), 64'd1);
        chk("r1_err", 64'(err_count), 64'd0);
        chk("r1_timeout", 64'(timeout), 64'd0);
        chk("r1_busy_end", 64'(busy), 64'd0);
        chk("r1_nwr", 64'(wr_n - wb), 64'd4);
        chk("r1_nrd", 64'(rd_n - rb), 64'd4);
        chk("r1_wa0", 64'(wr_log[wb[5:0]]), 64'd0);
        chk("r1_wa1", 64'(wr_log[6'(wb + 1)]), 64'd8);
        chk("r1_wa2", 64'(wr_log[6'(wb + 2)]), 64'd16);
        chk("r1_wa3", 64'(wr_log[6'(wb + 3)]), 64'd24);
        chk("r1_mem00", mem[0][0], 64'hA5A5_0000_FFFF_FFFE);
        chk("r1_mem01", mem[0][1], 64'hA5A5_0000_FFFF_FFFF);
        chk("r1_mem10", mem[1][0], 64'hA5A5_0001_FFFF_FFFC);
        chk("r1_mem31", mem[3][1], 64'hA5A5_0003_FFFF_FFF9);

        // start with init_done low leaves status alone
        init_done = 1'b0;
        pulse_start();
        tick(3);
        chk("hold_done", 64'(done), 64'd1);
        chk("hold_pass", 64'(pass), 64'd1);
        chk("hold_cmd_valid", 64'(ui.cmd_valid), 64'd0);
        init_done = 1'b1;

        // Run 2: corrupted beat 1 of command 2
        corrupt = 1'b1;
        pulse_start();
        chk("r2_done_clr", 64'(done), 64'd0);
        chk("r2_pass_clr", 64'(pass), 64'd0);
        wait_done("r2_done");
        chk("r2_err", 64'(err_count), 64'd1);
        chk("r2_first", 64'(first_err_addr), 64'd16);
        chk("r2_pass", 64'(pass), 64'd0);
        chk("r2_timeout", 64'(timeout), 64'd0);
        corrupt = 1'b0;

        // Run 3: cmd_rdy stall mid-write
        wb = wr_n;
        pulse_start();
        for (int k = 0; k < 200 && !(ui.cmd_valid && ui.addr == 26'd16); k++) @(negedge clk);
        chk("r3_reach16", 64'(ui.addr), 64'd16);
        ui.cmd_rdy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("r3_stall", {57'd0, ui.cmd_valid, ui.cmd, 2'd0},
                {57'd0, 1'b1, CMD_WR, 2'd0});
            chk("r3_stall_addr", 64'(ui.addr), 64'd16);
        end
        ui.cmd_rdy = 1'b1;
        wait_done("r3_done");
        chk("r3_pass", 64'(pass), 64'd1);
        chk("r3_err", 64'(err_count), 64'd0);
        chk("r3_nwr", 64'(wr_n - wb), 64'd4);

        // Run 4: reads never return
        no_read = 1'b1;
        pulse_start();
        wait_done("r4_done");
        chk("r4_timeout", 64'(timeout), 64'd1);
        chk("r4_pass", 64'(pass), 64'd0);
        chk("r4_cmd_valid", 64'(ui.cmd_valid), 64'd0);
        chk("r4_busy", 64'(busy), 64'd0);
        chk("r4_latency", 64'(cyc - 1 - last_prog), 64'd64);
        no_read = 1'b0;

        // Run 5: reset during RD_CMD
        pulse_start();
        for (int k = 0; k < 200 && !(ui.cmd_valid && ui.cmd == CMD_RD); k++) @(negedge clk);
        chk("r5_in_rd", 64'(ui.cmd), 64'(CMD_RD));
        rst = 1'b1;
        #1;
        chk_reset_vals("r5_rst");
        @(negedge clk);
        hs0 = n_hs;
        tick(3);
        rst = 1'b0;
        tick(50);
        chk("r5_no_cmds", 64'(n_hs - hs0), 64'd0);
        chk("r5_cmd_valid", 64'(ui.cmd_valid), 64'd0);
        chk("r5_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_ui_traffic_gen.md
# ddr3_ui_traffic_gen

Write/read-verify traffic generator that drives the local user interface of the DDR3 x16 memory controller inside `claritycores`, on the controller's `sclk` domain. It is the command-issuing and read-data-consuming end of that interface, which is otherwise tied off. After `init_done`, a `start` pulse makes it write a deterministic pattern to a contiguous region, read it back in order, and report pass/fail, error count and first failing address.

## Interface
- `NUM_CMDS`, 256: BL8 commands per phase; 1..65535.
- `BASE_ADDR`, 26'h0: first user address.
- `ADDR_STEP`, 8: address increment per command.
- `SEED`, 32'hA5A5_0000: pattern seed.
- `TIMEOUT`, 4096: max `sclk` cycles without progress before abort.
- `CMD_RD`, 4'b0001, and `CMD_WR`, 4'b0010: controller command codes.
- `clk` in 1: controller `sclk_out`.
- `rst` in 1: reset, asynchronous, active-high.
- `init_done` in 1: controller initialization complete, level.
- `start` in 1: one-cycle run request.
- `cmd` out 4: command code.
- `cmd_valid` out 1: command request.
- `cmd_rdy` in 1: controller accepts the command on `cmd_valid && cmd_rdy`.
- `addr` out 26: command address.
- `cmd_burst_cnt` out 5: constant 5'd1.
- `ofly_burst_len` out 1: constant 0.
- `datain_rdy` in 1: controller consumes `write_data` this cycle.
- `write_data` out 64: write beat.
- `data_mask` out 8: constant 0.
- `read_data` in 64: read beat.
- `read_data_valid` in 1: read beat strobe.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held until the next accepted `start`.
- `pass` out 1: valid when `done`; 1 when there are no errors and no timeout.
- `timeout` out 1: the run aborted on `TIMEOUT`.
- `err_count` out 16: mismatching beats; saturates at 16'hFFFF.
- `first_err_addr` out 26: command address of the first mismatching beat.

## Operation
- Each BL8 command carries 2 beats of 64 bits; beat index b∈{0,1}.
- For command index i (32-bit), pattern beat = {i ^ SEED, ~i[30:0], b}.
- States and transitions:
  - IDLE → WR_CMD on `start && init_done`. The accepting cycle clears `done`, `pass`, `timeout`, `err_count`, `first_err_addr` and all counters.
  - `start` is ignored when `init_done`=0 or `busy`=1.
  - WR_CMD: drive `cmd_valid`=1, `cmd`=CMD_WR, `addr`=BASE_ADDR+i·ADDR_STEP, mod 2^26. On acceptance → WR_DATA.
  - WR_DATA: present beat b of command i. Advance b on `datain_rdy`. After beat 1: i++, then go to WR_CMD, or to RD_CMD with i reset to 0 when i reaches NUM_CMDS.
  - RD_CMD: issue read commands back-to-back, one per accepted handshake, with the same address rule. After NUM_CMDS acceptances, deassert `cmd_valid` → RD_WAIT.
  - Read checking is independent of issue and runs in both RD_CMD and RD_WAIT. Each `read_data_valid` beat is compared against the pattern for the compare counter (command j, beat b), and the counter advances. The controller returns beats in order.
  - On mismatch: `err_count` increments (saturating). If this is the first mismatch, latch the address of command j.
  - RD_CMD/RD_WAIT → DONE when 2·NUM_CMDS beats have been compared.
  - DONE: `done`=1, `pass`=(`err_count`==0 && !`timeout`). Returns to IDLE internally, keeping the status outputs held.
- Timeout: the progress counter reloads on any handshake, `datain_rdy` or `read_data_valid`. Reaching TIMEOUT in any non-IDLE state → set `timeout`, drop `cmd_valid`, go to DONE.
- `cmd_valid`, `cmd` and `addr` stay stable until acceptance.

## Timing
- Reset values: `cmd_valid`=0, `cmd`=0, `addr`=0, `write_data`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `err_count`=0, `first_err_addr`=0; state IDLE.
- All outputs are registered.
- `busy` rises the cycle after the accepted `start`. `cmd_valid` asserts that same cycle.
- `write_data` for the next beat is valid the cycle after the `datain_rdy` that consumed the previous beat.
- Read compare registers for 1 cycle. `done` and `busy`=0 occur 2 cycles after the final `read_data_valid`.
- `rst` mid-run aborts immediately to reset values, and no further commands are issued.

## Test plan
- Ideal controller model (cmd_rdy=1, datain_rdy 1 cycle after acceptance, read latency 10), NUM_CMDS=4 -> 4 write commands at addresses 0, 8, 16, 24, then 4 reads; `done`=1, `pass`=1, `err_count`=0.
- Model corrupts read beat 1 of command 2 (bit 0 flipped) -> `err_count`=1, `first_err_addr`=16, `pass`=0.
- cmd_rdy held low for 20 cycles mid-write -> `cmd`/`addr` stable throughout; run completes with `pass`=1.
- Model never returns read data, TIMEOUT=64 -> `timeout`=1 64 cycles after the last progress; `done`=1, `pass`=0, `cmd_valid`=0.
- `start` with `init_done`=0, and `start` while `busy` -> ignored; no `cmd_valid`; status unchanged.
- `rst` asserted during RD_CMD -> all outputs return to reset values the same cycle; no commands issued afterward.
